// File: rtl/feat_bram_streamer.sv
// Streams the feature BRAM (port B) out as a valid/ready beat stream.
// Optional running checksum of sent beats: define FEAT_STREAM_CHECKSUM_EN.
module feat_bram_streamer #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int DEPTH           = 43328,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int LEN_W           = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_node_end,
  output logic [15:0]           checksum
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam int NODE_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_FEATURE_OUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [LEN_W-1:0]      r_len_eff, r_rd_ptr, r_ld_cnt;
  logic [ADDR_W-1:0]     r_addrb;
  logic                  r_outst;
  logic [DATA_WIDTH-1:0] r_fifo_mem [0:1];
  logic                  r_fifo_wp, r_fifo_rp;
  logic [1:0]            r_fifo_cnt;
  logic                  r_m_valid, r_m_last, r_m_node;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [NODE_W-1:0]     r_node_cnt;
  logic                  r_busy, r_done;

  logic [LEN_W-1:0] w_len_clamp;
  logic [2:0]       w_inflight;
  logic             w_start_acc, w_hs, w_load, w_issue, w_last_hs;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_hs        = r_m_valid && m_ready;
  assign w_last_hs   = w_hs && r_m_last;
  // The output register refills from the skid FIFO whenever it empties or hands off.
  assign w_load      = (r_fifo_cnt != 2'd0) && (!r_m_valid || m_ready);
  // Credit counts the FIFO entry leaving this cycle so a full-rate stream never stalls.
  assign w_inflight  = {1'b0, r_fifo_cnt} + {2'b0, r_outst} - {2'b0, w_load};
  assign w_issue     = (r_state == S_RUN) && (r_rd_ptr < r_len_eff) && (w_inflight < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_rd_ptr == r_len_eff) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_last_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_eff     <= '0;
      r_rd_ptr      <= '0;
      r_ld_cnt      <= '0;
      r_addrb       <= '0;
      r_outst       <= 1'b0;
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_fifo_wp     <= 1'b0;
      r_fifo_rp     <= 1'b0;
      r_fifo_cnt    <= 2'd0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_m_last      <= 1'b0;
      r_m_node      <= 1'b0;
      r_node_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done  <= (r_state == S_DONE);
      r_outst <= w_issue;
      if (w_start_acc)             r_busy <= 1'b1;
      else if (r_state == S_DONE)  r_busy <= 1'b0;

      if (w_start_acc) begin
        r_len_eff  <= w_len_clamp;
        r_rd_ptr   <= '0;
        r_addrb    <= '0;
        r_ld_cnt   <= '0;
        r_node_cnt <= '0;
      end else begin
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + LEN_W'(1);
          // Park on the last valid address instead of stepping past len_eff-1.
          if (r_rd_ptr + LEN_W'(1) < r_len_eff)
            r_addrb <= ADDR_W'(r_rd_ptr + LEN_W'(1));
        end
        if (w_load) begin
          r_ld_cnt   <= r_ld_cnt + LEN_W'(1);
          r_node_cnt <= (r_node_cnt == NODE_LAST) ? '0 : r_node_cnt + NODE_W'(1);
        end
      end

      if (r_outst) begin
        r_fifo_mem[r_fifo_wp] <= bram_doutb;
        r_fifo_wp             <= ~r_fifo_wp;
      end
      if (w_load) r_fifo_rp <= ~r_fifo_rp;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_outst} - {1'b0, w_load};

      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_fifo_mem[r_fifo_rp];
        r_m_last  <= (r_ld_cnt == r_len_eff - LEN_W'(1));
        r_m_node  <= (r_node_cnt == NODE_LAST);
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign bram_addrb = r_addrb;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign m_node_end = r_m_node;

`ifdef FEAT_STREAM_CHECKSUM_EN
  logic [15:0] r_csum;
  always_ff @(posedge clk) begin
    if (!rst_n)           r_csum <= '0;
    else if (w_start_acc) r_csum <= '0;
    else if (w_hs)        r_csum <= r_csum + 16'(r_m_data);
  end
  assign checksum = r_csum;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_feat_bram_streamer.sv
// Directed bench for feat_bram_streamer with a 1-cycle registered BRAM model.
module tb_feat_bram_streamer;
  localparam int DEPTH = 43328;

  logic        clk = 1'b0;
  logic        rst_n, start, m_ready;
  logic [16:0] len;
  logic        busy, done, m_valid, m_last, m_node_end;
  logic [15:0] bram_addrb, checksum;
  logic [7:0]  bram_doutb, m_data;
  logic [7:0]  mem [0:DEPTH-1];

  int checks = 0, failures = 0;
  int k, n_beats, first_v, last_hs_k, done_k, done_cnt, last_data, max_addr;
  int data_err, stab_err, last_err, node_err;
  logic [15:0] csum_at_done;

  feat_bram_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
    .bram_addrb(bram_addrb), .bram_doutb(bram_doutb), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_node_end(m_node_end),
    .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bram_doutb <= mem[bram_addrb];

  task automatic pulse_start(input int L);
    @(negedge clk); start = 1'b1; len = 17'(L);
    @(negedge clk); start = 1'b0;
  endtask

  // Runs from the first negedge after the accepting edge (k=0) and records what it sees.
  task automatic stream(input int L, input bit rnd, input int max_k, input int rs_k, input int rs_len);
    bit pend; logic [7:0] pd; logic pl, pn; int b;
    n_beats = 0; first_v = -1; last_hs_k = -1; done_k = -1; done_cnt = 0; last_data = -1;
    max_addr = 0; data_err = 0; stab_err = 0; last_err = 0; node_err = 0; csum_at_done = 16'hffff;
    pend = 0; pd = '0; pl = 0; pn = 0; k = 0;
    while (k <= max_k) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (k == rs_k);
      if (k == rs_k) len = 17'(rs_len);
      if (int'(bram_addrb) > max_addr) max_addr = int'(bram_addrb);
      if (m_valid) begin
        if (first_v < 0) first_v = k;
        if (pend && (m_data !== pd || m_last !== pl || m_node_end !== pn)) stab_err++;
        b = n_beats;
        if (m_data !== 8'(b % 256)) data_err++;
        if (m_last !== (b == L - 1)) last_err++;
        if (m_node_end !== (b % 16 == 15)) node_err++;
        if (m_ready) begin
          n_beats++; last_hs_k = k; last_data = int'(m_data); pend = 0;
        end else begin
          pend = 1; pd = m_data; pl = m_last; pn = m_node_end;
        end
      end else if (pend) stab_err++;
      if (done) begin done_cnt++; done_k = k; csum_at_done = checksum; end
      if (done_cnt > 0 && k >= done_k + 3) break;
      @(negedge clk); k++;
    end
    start = 1'b0; m_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, m_valid, m_last, m_node_end} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, m_valid, m_last, m_node_end}); end
    checks++; if (m_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", m_data); end
    checks++; if (bram_addrb !== 16'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bram_addrb); end
    checks++; if (checksum !== 16'd0) begin failures++; $display("FAIL reset_csum got=%0d exp=0", checksum); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] exp_csum;
`ifdef FEAT_STREAM_CHECKSUM_EN
    exp_csum = 16'd496;
`else
    exp_csum = 16'd0;
`endif
    pulse_start(32);
    stream(32, 1'b0, 200, -1, 0);
    checks++; if (n_beats !== 32) begin failures++; $display("FAIL basic_beats got=%0d exp=32", n_beats); end
    checks++; if (first_v !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", first_v); end
    checks++; if (last_hs_k !== 34) begin failures++; $display("FAIL basic_rate last_hs=%0d exp=34", last_hs_k); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL basic_data errs=%0d exp=0", data_err); end
    checks++; if (node_err !== 0) begin failures++; $display("FAIL basic_node_end errs=%0d exp=0", node_err); end
    checks++; if (last_err !== 0) begin failures++; $display("FAIL basic_last errs=%0d exp=0", last_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_k !== 36) begin failures++; $display("FAIL basic_done_time got=%0d exp=36", done_k); end
    checks++; if (csum_at_done !== exp_csum) begin failures++;
      $display("FAIL basic_checksum got=%0d exp=%0d", csum_at_done, exp_csum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    pulse_start(40);
    stream(40, 1'b1, 400, -1, 0);
    checks++; if (n_beats !== 40) begin failures++; $display("FAIL bp_beats got=%0d exp=40", n_beats); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL bp_order errs=%0d exp=0", data_err); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable errs=%0d exp=0", stab_err); end
    checks++; if (last_err !== 0) begin failures++; $display("FAIL bp_last errs=%0d exp=0", last_err); end
    checks++; if (done_cnt !== 1 || done_k !== last_hs_k + 2) begin failures++;
      $display("FAIL bp_done cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_k, last_hs_k + 2); end
  endtask

  task automatic test_len0;
    int nv;
    pulse_start(0);
    nv = int'(m_valid);
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL len0_c0 busy_done=%b exp=10", {busy, done}); end
    @(negedge clk); nv += int'(m_valid);
    checks++; if ({busy, done} !== 2'b01) begin failures++; $display("FAIL len0_c1 busy_done=%b exp=01", {busy, done}); end
    @(negedge clk); nv += int'(m_valid);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL len0_pulse done=%b exp=0", done); end
    checks++; if (nv !== 0) begin failures++; $display("FAIL len0_valid got=%0d exp=0", nv); end
  endtask

  task automatic test_clamp;
    pulse_start(50000);
    stream(DEPTH, 1'b0, 44000, -1, 0);
    checks++; if (n_beats !== DEPTH) begin failures++; $display("FAIL clamp_beats got=%0d exp=%0d", n_beats, DEPTH); end
    checks++; if (max_addr !== DEPTH - 1) begin failures++; $display("FAIL clamp_addr got=%0d exp=%0d", max_addr, DEPTH - 1); end
    checks++; if (last_data !== 63) begin failures++; $display("FAIL clamp_last_data got=%0d exp=63", last_data); end
    checks++; if (last_err !== 0 || data_err !== 0) begin failures++;
      $display("FAIL clamp_stream last_errs=%0d data_errs=%0d exp=0", last_err, data_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL clamp_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_restart_ignored;
    pulse_start(16);
    stream(16, 1'b0, 200, 5, 4);
    checks++; if (n_beats !== 16) begin failures++; $display("FAIL restart_beats got=%0d exp=16", n_beats); end
    checks++; if (last_err !== 0) begin failures++; $display("FAIL restart_last errs=%0d exp=0", last_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid;
    int n, nd, nv, cyc;
    n = 0; cyc = 0;
    pulse_start(16);
    while (n < 5 && cyc < 50) begin
      m_ready = 1'b1;
      if (m_valid) n++;
      if (n == 5) rst_n = 1'b0;
      else begin @(negedge clk); cyc++; end
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL rmid_reach beats=%0d exp=5", n); end
    @(negedge clk);
    checks++; if ({m_valid, busy} !== 2'b00) begin failures++; $display("FAIL rmid_abort valid_busy=%b exp=00", {m_valid, busy}); end
    rst_n = 1'b1; nd = 0; nv = 0;
    repeat (10) begin @(negedge clk); nd += int'(done); nv += int'(m_valid); end
    checks++; if (nd !== 0 || nv !== 0) begin failures++; $display("FAIL rmid_quiet done=%0d valid=%0d exp=0", nd, nv); end
    pulse_start(4);
    stream(4, 1'b0, 100, -1, 0);
    checks++; if (n_beats !== 4 || data_err !== 0) begin failures++;
      $display("FAIL rmid_restart beats=%0d data_errs=%0d exp=4,0", n_beats, data_err); end
    checks++; if (first_v !== 3) begin failures++; $display("FAIL rmid_latency got=%0d exp=3", first_v); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i % 256);
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_restart_ignored();
    test_reset_mid();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
